pipe_ctrl: RTL



---
 rtl/pipe_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall/flush generation, exception/interrupt/ERET
// redirect, and the control-register file (STATUS, PRE_STATUS, EPC, EXP_VECTOR, EXP_CODE).
module pipe_ctrl #(
  parameter int unsigned ADD_WIDTH   = 30,
  parameter int unsigned DAT_WIDTH   = 32,
  parameter int unsigned REG_ADD_BUS = 5,
  parameter int unsigned CTRL_OP_BUS = 2,
  parameter int unsigned ISA_EXP_BUS = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   if_busy_i,
  input  logic                   mem_busy_i,
  input  logic                   ld_hazard_i,
  input  logic                   mem_en_i,
  input  logic [ADD_WIDTH-1:0]   mem_pc_i,
  input  logic [ISA_EXP_BUS-1:0] mem_exp_code_i,
  input  logic [CTRL_OP_BUS-1:0] mem_ctrl_op_i,
  input  logic                   irq_i,
  input  logic                   creg_we_i,
  input  logic [REG_ADD_BUS-1:0] creg_wr_addr_i,
  input  logic [DAT_WIDTH-1:0]   creg_wr_data_i,
  input  logic [REG_ADD_BUS-1:0] creg_rd_addr_i,
  output logic [DAT_WIDTH-1:0]   creg_rd_data_o,
  output logic                   if_stall_o,
  output logic                   id_stall_o,
  output logic                   ex_stall_o,
  output logic                   mem_stall_o,
  output logic                   if_flush_o,
  output logic                   id_flush_o,
  output logic                   ex_flush_o,
  output logic                   mem_flush_o,
  output logic [ADD_WIDTH-1:0]   new_pc_o,
  output logic                   exe_mode_o,
  output logic                   int_en_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam logic [CTRL_OP_BUS-1:0] OP_ERET    = CTRL_OP_BUS'(2);
  localparam logic [ISA_EXP_BUS-1:0] CODE_INTR  = ISA_EXP_BUS'(1);
  localparam logic [REG_ADD_BUS-1:0] A_STATUS   = REG_ADD_BUS'(0);
  localparam logic [REG_ADD_BUS-1:0] A_PRE_STAT = REG_ADD_BUS'(1);
  localparam logic [REG_ADD_BUS-1:0] A_EPC      = REG_ADD_BUS'(2);
  localparam logic [REG_ADD_BUS-1:0] A_EXP_VEC  = REG_ADD_BUS'(3);
  localparam logic [REG_ADD_BUS-1:0] A_EXP_CODE = REG_ADD_BUS'(4);

  logic                   r_irq_meta;
  logic                   r_irq_s;
  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [1:0]             r_status;
  logic [1:0]             r_pre_status;
  logic [ADD_WIDTH-1:0]   r_epc;
  logic [ADD_WIDTH-1:0]   r_exp_vec;
  logic [ISA_EXP_BUS-1:0] r_exp_code;
  logic                   r_lat_eret;
  logic [ISA_EXP_BUS-1:0] r_lat_code;
  logic [ADD_WIDTH-1:0]   r_lat_pc;

  logic                   w_exc;
  logic                   w_eret;
  logic                   w_intr;
  logic                   w_evt;
  logic [ISA_EXP_BUS-1:0] w_cur_code;
  logic                   w_latch;
  logic                   w_redir;
  logic                   w_rd_eret;
  logic [ISA_EXP_BUS-1:0] w_rd_code;
  logic [ADD_WIDTH-1:0]   w_rd_pc;

  // Event decode for the instruction currently in MEM
  assign w_exc      = mem_en_i & (mem_exp_code_i != '0);
  assign w_eret     = mem_en_i & (mem_ctrl_op_i == OP_ERET) & ~w_exc;
  assign w_intr     = r_irq_s & r_status[1] & mem_en_i & ~w_exc & ~w_eret;
  assign w_evt      = w_exc | w_eret | w_intr;
  assign w_cur_code = w_exc ? mem_exp_code_i : CODE_INTR;

  // Two-flop synchronizer for the asynchronous interrupt line
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_irq_meta <= 1'b0;
      r_irq_s    <= 1'b0;
    end else begin
      r_irq_meta <= irq_i;
      r_irq_s    <= r_irq_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= RUN;
      r_lat_eret <= 1'b0;
      r_lat_code <= '0;
      r_lat_pc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_lat_eret <= w_eret;
        r_lat_code <= w_cur_code;
        r_lat_pc   <= mem_pc_i;
      end
    end
  end

  // An event seen while MEM is busy is parked in PEND until the bus frees up
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_redir     = 1'b0;
    w_rd_eret   = r_lat_eret;
    w_rd_code   = r_lat_code;
    w_rd_pc     = r_lat_pc;
    case (r_state)
      RUN: begin
        if (w_evt) begin
          if (mem_busy_i) begin
            w_latch     = 1'b1;
            w_state_nxt = PEND;
          end else begin
            w_redir   = 1'b1;
            w_rd_eret = w_eret;
            w_rd_code = w_cur_code;
            w_rd_pc   = mem_pc_i;
          end
        end
      end
      PEND: begin
        if (!mem_busy_i) begin
          w_redir     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    if_stall_o  = 1'b0;
    id_stall_o  = 1'b0;
    ex_stall_o  = 1'b0;
    mem_stall_o = 1'b0;
    if_flush_o  = 1'b0;
    id_flush_o  = 1'b0;
    ex_flush_o  = 1'b0;
    mem_flush_o = 1'b0;
    new_pc_o    = '0;
    if (w_redir) begin
      if_flush_o  = 1'b1;
      id_flush_o  = 1'b1;
      ex_flush_o  = 1'b1;
      mem_flush_o = 1'b1;
      new_pc_o    = w_rd_eret ? r_epc : r_exp_vec;
    end else if (if_busy_i | mem_busy_i) begin
      if_stall_o  = 1'b1;
      id_stall_o  = 1'b1;
      ex_stall_o  = 1'b1;
      mem_stall_o = 1'b1;
    end else if (ld_hazard_i) begin
      if_stall_o = 1'b1;
      id_stall_o = 1'b1;
      id_flush_o = 1'b1;
    end
  end

  // Control registers; redirect updates are written last so they win over a same-cycle write
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_status     <= '0;
      r_pre_status <= '0;
      r_epc        <= '0;
      r_exp_vec    <= '0;
      r_exp_code   <= '0;
    end else begin
      if (creg_we_i) begin
        case (creg_wr_addr_i)
          A_STATUS:   r_status     <= creg_wr_data_i[1:0];
          A_PRE_STAT: r_pre_status <= creg_wr_data_i[1:0];
          A_EPC:      r_epc        <= creg_wr_data_i[ADD_WIDTH+1:2];
          A_EXP_VEC:  r_exp_vec    <= creg_wr_data_i[ADD_WIDTH+1:2];
          A_EXP_CODE: r_exp_code   <= creg_wr_data_i[ISA_EXP_BUS-1:0];
          default: ;
        endcase
      end
      if (w_redir) begin
        if (w_rd_eret) begin
          r_status <= r_pre_status;
        end else begin
          r_pre_status <= r_status;
          r_status     <= 2'b00;
          r_epc        <= w_rd_pc;
          r_exp_code   <= w_rd_code;
        end
      end
    end
  end

  always_comb begin
    creg_rd_data_o = '0;
    case (creg_rd_addr_i)
      A_STATUS:   creg_rd_data_o = DAT_WIDTH'(r_status);
      A_PRE_STAT: creg_rd_data_o = DAT_WIDTH'(r_pre_status);
      A_EPC:      creg_rd_data_o = DAT_WIDTH'({r_epc, 2'b00});
      A_EXP_VEC:  creg_rd_data_o = DAT_WIDTH'({r_exp_vec, 2'b00});
      A_EXP_CODE: creg_rd_data_o = DAT_WIDTH'(r_exp_code);
      default:    creg_rd_data_o = '0;
    endcase
  end

  assign exe_mode_o = r_status[0];
  assign int_en_o   = r_status[1];

endmodule
